// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizing helpers for the multi-port masked RAM.
package ram_pkg;

  typedef enum logic {RAM_INIT, RAM_RUN} ram_state_t;

  // Requester address ports are always this wide; only the low bits index the array.
  localparam int PORT_ADDR_W = 32;

  // Number of independently writable lanes in a word.
  function automatic int lane_count(input int dataWidth, input int laneWidth);
    return dataWidth / laneWidth;
  endfunction

  // Word address width for a power-of-two depth (at least one bit).
  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Width needed to hold a port index (at least one bit).
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among N requesters; owns the rotating priority pointer.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [N-1:0]               req_i,
  input  logic                       advance_i,
  output logic [N-1:0]               grant_o,
  output logic [index_width(N)-1:0]  grant_idx_o,
  output logic                       any_o
);

  localparam int IDX_W = index_width(N);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_next;

  // Grant the first asserted request at or after the pointer, wrapping past N-1.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[(int'(r_ptr) + k) % N]) begin
        any_o                          = 1'b1;
        grant_idx_o                    = IDX_W'((int'(r_ptr) + k) % N);
        grant_o[(int'(r_ptr) + k) % N] = 1'b1;
      end
    end
  end

  assign w_next = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);

  // Move priority to the port after the grantee; hold it when nobody was granted.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (advance_i && any_o) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/ram_mp.sv
// ram_mp: multi-port lane-masked RAM with power-on clear, round-robin access and
// fixed-latency per-port read responses. Successor of the single-port nibble-masked RAM.
module ram_mp
  import ram_pkg::*;
#(
  parameter int SIZE         = 65536,
  parameter int DATA_WIDTH   = 16,
  parameter int LANE_WIDTH   = 4,
  parameter int NB_PORTS     = 2,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                                                clk,
  input  logic                                                reset_i,
  output logic                                                init_done_o,
  input  logic [NB_PORTS-1:0]                                 req_valid_i,
  output logic [NB_PORTS-1:0]                                 req_ready_o,
  input  logic [NB_PORTS-1:0]                                 req_wr_en_i,
  input  logic [NB_PORTS*lane_count(DATA_WIDTH, LANE_WIDTH)-1:0] req_wr_mask_i,
  input  logic [NB_PORTS*PORT_ADDR_W-1:0]                     req_address_i,
  input  logic [NB_PORTS*DATA_WIDTH-1:0]                      req_data_i,
  output logic [NB_PORTS-1:0]                                 rsp_valid_o,
  output logic [NB_PORTS*DATA_WIDTH-1:0]                      rsp_data_o
);

  localparam int NB_LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int ADDR_W   = addr_width(SIZE);
  localparam int PID_W    = index_width(NB_PORTS);

  ram_state_t              r_state;
  logic [ADDR_W-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [SIZE];

  logic                    w_run;
  logic                    w_clear;
  logic [NB_PORTS-1:0]     w_arb_req;
  logic [NB_PORTS-1:0]     w_grant;
  logic [PID_W-1:0]        w_gidx;
  logic                    w_any;
  logic                    w_wr_sel;
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic [ADDR_W-1:0]       w_addr;
  logic [NB_LANES-1:0]     w_mask;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_out_v;
  logic [PID_W-1:0]        w_out_pid;
  logic [DATA_WIDTH-1:0]   w_out_data;
  logic                    w_unused;

  assign w_run     = (r_state == RAM_RUN);
  assign w_clear   = (r_state == RAM_INIT) && (INIT_CLEAR != 0);
  assign w_arb_req = req_valid_i & {NB_PORTS{w_run}};

  rr_arbiter #(
    .N (NB_PORTS)
  ) u_arb (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_i       (w_arb_req),
    .advance_i   (w_run),
    .grant_o     (w_grant),
    .grant_idx_o (w_gidx),
    .any_o       (w_any)
  );

  assign req_ready_o = w_grant;

  // Upper address bits only select aliases of the same word.
  assign w_wr_sel  = req_wr_en_i[w_gidx];
  assign w_addr    = req_address_i[int'(w_gidx)*PORT_ADDR_W +: ADDR_W];
  assign w_mask    = req_wr_mask_i[int'(w_gidx)*NB_LANES +: NB_LANES];
  assign w_wdata   = req_data_i[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_wr_fire = w_any & w_wr_sel;
  assign w_rd_fire = w_any & ~w_wr_sel;
  assign w_rdata   = r_mem[w_addr];
  assign w_unused  = ^req_address_i;

  // Sequence INIT (optional zero-fill sweep) into the terminal RUN state.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= RAM_INIT;
      r_cnt       <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (r_state)
        RAM_INIT: begin
          if (INIT_CLEAR != 0) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == ADDR_W'(SIZE - 1)) begin
              r_state     <= RAM_RUN;
              init_done_o <= 1'b1;
            end
          end else begin
            r_state     <= RAM_RUN;
            init_done_o <= 1'b1;
          end
        end
        RAM_RUN: begin
          init_done_o <= 1'b1;
        end
        default: begin
          r_state     <= RAM_INIT;
          init_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: clear sweep during INIT, otherwise lane-masked requester writes.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int l = 0; l < NB_LANES; l++) begin
        if (w_mask[l]) begin
          r_mem[w_addr][l*LANE_WIDTH +: LANE_WIDTH] <= w_wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_direct
    assign w_out_v    = w_rd_fire;
    assign w_out_pid  = w_gidx;
    assign w_out_data = w_rdata;
  end else begin : g_pipe
    localparam int STAGES = READ_LATENCY - 1;

    logic                  r_pv  [STAGES];
    logic [PID_W-1:0]      r_pid [STAGES];
    logic [DATA_WIDTH-1:0] r_pd  [STAGES];

    // Carry accepted reads through the extra latency stages; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        for (int s = 0; s < STAGES; s++) begin
          r_pv[s]  <= 1'b0;
          r_pid[s] <= '0;
          r_pd[s]  <= '0;
        end
      end else begin
        r_pv[0]  <= w_rd_fire;
        r_pid[0] <= w_gidx;
        r_pd[0]  <= w_rdata;
        for (int s = 1; s < STAGES; s++) begin
          r_pv[s]  <= r_pv[s-1];
          r_pid[s] <= r_pid[s-1];
          r_pd[s]  <= r_pd[s-1];
        end
      end
    end

    assign w_out_v    = r_pv[STAGES-1];
    assign w_out_pid  = r_pid[STAGES-1];
    assign w_out_data = r_pd[STAGES-1];
  end

  // Route each completed read to its port: one-cycle valid pulse, data held until the next one.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= '0;
      if (w_out_v) begin
        rsp_valid_o[w_out_pid]                               <= 1'b1;
        rsp_data_o[int'(w_out_pid)*DATA_WIDTH +: DATA_WIDTH] <= w_out_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_mp.sv
// tb_ram_mp: directed checks of ram_mp on two configurations:
// dutA = 16 words, 1-cycle reads, zero-fill; dutB = 64K words, 3-cycle reads, no zero-fill.
module tb_ram_mp;

  typedef struct {
    int          port;
    logic        wrEn;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [15:0] data;
    logic [15:0] expData;
  } vec_t;

  logic        clk;
  logic        aReset, bReset;
  logic        aInitDone, bInitDone;
  logic [1:0]  aValid, aReady, aWrEn, aRspValid;
  logic [1:0]  bValid, bReady, bWrEn, bRspValid;
  logic [7:0]  aMask, bMask;
  logic [63:0] aAddr, bAddr;
  logic [31:0] aData, bData, aRspData, bRspData;

  int   checkCount;
  int   errorCount;
  vec_t vecs[$];

  ram_mp #(
    .SIZE(16), .DATA_WIDTH(16), .LANE_WIDTH(4), .NB_PORTS(2), .READ_LATENCY(1), .INIT_CLEAR(1)
  ) dutA (
    .clk(clk), .reset_i(aReset), .init_done_o(aInitDone),
    .req_valid_i(aValid), .req_ready_o(aReady), .req_wr_en_i(aWrEn),
    .req_wr_mask_i(aMask), .req_address_i(aAddr), .req_data_i(aData),
    .rsp_valid_o(aRspValid), .rsp_data_o(aRspData)
  );

  ram_mp #(
    .SIZE(65536), .DATA_WIDTH(16), .LANE_WIDTH(4), .NB_PORTS(2), .READ_LATENCY(3), .INIT_CLEAR(0)
  ) dutB (
    .clk(clk), .reset_i(bReset), .init_done_o(bInitDone),
    .req_valid_i(bValid), .req_ready_o(bReady), .req_wr_en_i(bWrEn),
    .req_wr_mask_i(bMask), .req_address_i(bAddr), .req_data_i(bData),
    .rsp_valid_o(bRspValid), .rsp_data_o(bRspData)
  );

  // Free-running 10ns clock shared by both instances.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int port, input logic wrEn, input logic [3:0] mask,
                              input logic [31:0] addr, input logic [15:0] data,
                              input logic [15:0] expData);
    vec_t v;
    v.port    = port;
    v.wrEn    = wrEn;
    v.mask    = mask;
    v.addr    = addr;
    v.data    = data;
    v.expData = expData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One single-requester transaction on dutA: request cycle, then the cycle after.
  task automatic applyStimulus(input vec_t v);
    aValid                   = 2'b00;
    aValid[v.port]           = 1'b1;
    aWrEn[v.port]            = v.wrEn;
    aMask[v.port*4 +: 4]     = v.mask;
    aAddr[v.port*32 +: 32]   = v.addr;
    aData[v.port*16 +: 16]   = v.data;
    #1;
    checkOutput($sformatf("a_ready_p%0d_addr%0h", v.port, v.addr), 32'(aReady), 32'(1) << v.port);
    @(negedge clk);
    aValid = 2'b00;
    #1;
    if (v.wrEn) begin
      checkOutput($sformatf("a_wr_no_rsp_addr%0h", v.addr), 32'(aRspValid), 32'd0);
    end else begin
      checkOutput($sformatf("a_rsp_valid_p%0d_addr%0h", v.port, v.addr), 32'(aRspValid), 32'(1) << v.port);
      checkOutput($sformatf("a_rsp_data_p%0d_addr%0h", v.port, v.addr), 32'(aRspData[v.port*16 +: 16]), 32'(v.expData));
    end
  endtask

  // Present one full-mask request on dutB and confirm it is granted immediately.
  task automatic bDrive(input int port, input logic wrEn, input logic [31:0] addr, input logic [15:0] data);
    bValid                 = 2'b00;
    bValid[port]           = 1'b1;
    bWrEn[port]            = wrEn;
    bMask[port*4 +: 4]     = 4'hF;
    bAddr[port*32 +: 32]   = addr;
    bData[port*16 +: 16]   = data;
    #1;
    checkOutput($sformatf("b_ready_p%0d_addr%0h", port, addr), 32'(bReady), 32'(1) << port);
  endtask

  // Advance dutB one cycle with no request and check the response outputs.
  task automatic bStep(input string name, input logic [1:0] expValid, input int port, input logic [15:0] expData);
    @(negedge clk);
    bValid = 2'b00;
    #1;
    checkOutput({name, "_valid"}, 32'(bRspValid), 32'(expValid));
    if (expValid != 2'b00) begin
      checkOutput({name, "_data"}, 32'(bRspData[port*16 +: 16]), 32'(expData));
    end
  endtask

  // Main sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
    aReset = 1'b0; bReset = 1'b0;
    aValid = '0; aWrEn = '0; aMask = '0; aAddr = '0; aData = '0;
    bValid = '0; bWrEn = '0; bMask = '0; bAddr = '0; bData = '0;
    #2;
    aReset = 1'b1;
    bReset = 1'b1;

    // ---------------- dutA: reset state and zero-fill timing ----------------
    @(negedge clk);
    aValid = 2'b11;
    #1;
    checkOutput("a_reset_ready", 32'(aReady), 32'd0);
    checkOutput("a_reset_init_done", 32'(aInitDone), 32'd0);
    checkOutput("a_reset_rsp_valid", 32'(aRspValid), 32'd0);
    checkOutput("a_reset_rsp_data", aRspData, 32'd0);
    aValid = 2'b00;
    @(negedge clk);
    aReset = 1'b0;
    repeat (15) @(negedge clk);
    aValid = 2'b11;
    #1;
    checkOutput("a_init_ready_low", 32'(aReady), 32'd0);
    checkOutput("a_init_done_at15", 32'(aInitDone), 32'd0);
    aValid = 2'b00;
    @(negedge clk);
    #1;
    checkOutput("a_init_done_at16", 32'(aInitDone), 32'd1);

    // ---------------- dutA: table of single transactions ----------------
    for (int a = 0; a < 16; a++) begin
      vecs.push_back(mk(a % 2, 1'b0, 4'h0, 32'(a), 16'h0000, 16'h0000));
    end
    vecs.push_back(mk(0, 1'b1, 4'b1111, 32'd5,        16'hABCD, 16'h0000));
    vecs.push_back(mk(0, 1'b0, 4'b0000, 32'd5,        16'h0000, 16'hABCD));
    vecs.push_back(mk(0, 1'b1, 4'b0101, 32'd5,        16'h1234, 16'h0000));
    vecs.push_back(mk(1, 1'b0, 4'b0000, 32'd5,        16'h0000, 16'hA2C4));
    vecs.push_back(mk(1, 1'b1, 4'b0000, 32'd7,        16'hFFFF, 16'h0000));
    vecs.push_back(mk(0, 1'b0, 4'b0000, 32'd7,        16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1'b1, 4'b1000, 32'd15,       16'h5A5A, 16'h0000));
    vecs.push_back(mk(0, 1'b0, 4'b0000, 32'd15,       16'h0000, 16'h5000));
    vecs.push_back(mk(0, 1'b1, 4'b1111, 32'd18,       16'h0F0F, 16'h0000));
    vecs.push_back(mk(1, 1'b0, 4'b0000, 32'd2,        16'h0000, 16'h0F0F));
    vecs.push_back(mk(0, 1'b0, 4'b0000, 32'h0000_0012, 16'h0000, 16'h0F0F));
    vecs.push_back(mk(0, 1'b1, 4'b0011, 32'd3,        16'hFFC3, 16'h0000));
    vecs.push_back(mk(1, 1'b0, 4'b0000, 32'h8000_0013, 16'h0000, 16'h00C3));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // ---------------- dutA: both ports requesting every cycle ----------------
    // The last table entry was granted to port 1, so priority now sits on port 0.
    aWrEn = 2'b00;
    aAddr[31:0]  = 32'd5;
    aAddr[63:32] = 32'd15;
    aValid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("a_rr_ready_c%0d", c), 32'(aReady), (c % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      checkOutput($sformatf("a_rr_rsp_valid_c%0d", c), 32'(aRspValid), (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c % 2 == 0) begin
        checkOutput($sformatf("a_rr_rsp_data_c%0d", c), 32'(aRspData[15:0]), 32'h0000_A2C4);
      end else begin
        checkOutput($sformatf("a_rr_rsp_data_c%0d", c), 32'(aRspData[31:16]), 32'h0000_5000);
      end
    end
    aValid = 2'b00;

    // ---------------- dutA: reset mid-INIT restarts the clear ----------------
    @(negedge clk);
    aReset = 1'b1;
    #1;
    checkOutput("a_rerst_rsp_data", aRspData, 32'd0);
    checkOutput("a_rerst_init_done", 32'(aInitDone), 32'd0);
    @(negedge clk);
    aReset = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    checkOutput("a_mid_init_done", 32'(aInitDone), 32'd0);
    aReset = 1'b1;
    @(negedge clk);
    aReset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("a_restart_done_at15", 32'(aInitDone), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("a_restart_done_at16", 32'(aInitDone), 32'd1);
    applyStimulus(mk(0, 1'b0, 4'h0, 32'd15, 16'h0000, 16'h0000));
    applyStimulus(mk(1, 1'b0, 4'h0, 32'd5,  16'h0000, 16'h0000));

    // ---------------- dutB: reset state and one-cycle INIT ----------------
    bValid = 2'b11;
    #1;
    checkOutput("b_reset_ready", 32'(bReady), 32'd0);
    checkOutput("b_reset_init_done", 32'(bInitDone), 32'd0);
    checkOutput("b_reset_rsp_valid", 32'(bRspValid), 32'd0);
    bValid = 2'b00;
    @(negedge clk);
    bReset = 1'b0;
    #1;
    checkOutput("b_init_done_before", 32'(bInitDone), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("b_init_done_after1", 32'(bInitDone), 32'd1);

    // Seed two words, then read through the 64K alias right after the write.
    bDrive(1, 1'b1, 32'd2, 16'h1357);
    bStep("b_wr2", 2'b00, 0, 16'h0000);
    bDrive(0, 1'b1, 32'd3, 16'hBEEF);
    bStep("b_wr3", 2'b00, 0, 16'h0000);
    bDrive(0, 1'b0, 32'h0001_0003, 16'h0000);
    bStep("b_alias_c1", 2'b00, 0, 16'h0000);
    bStep("b_alias_c2", 2'b00, 0, 16'h0000);
    bStep("b_alias_c3", 2'b01, 0, 16'hBEEF);
    bStep("b_alias_c4", 2'b00, 0, 16'h0000);
    checkOutput("b_alias_data_held", 32'(bRspData[15:0]), 32'h0000_BEEF);

    // Port 1 read: pulse only in the third cycle after the request cycle.
    bDrive(1, 1'b0, 32'd2, 16'h0000);
    bStep("b_lat_c1", 2'b00, 1, 16'h0000);
    bStep("b_lat_c2", 2'b00, 1, 16'h0000);
    bStep("b_lat_c3", 2'b10, 1, 16'h1357);
    bStep("b_lat_c4", 2'b00, 1, 16'h0000);

    // Back-to-back reads on port 0 come back on consecutive cycles in order.
    bDrive(0, 1'b0, 32'd3, 16'h0000);
    bStep("b_b2b_c1", 2'b00, 0, 16'h0000);
    bDrive(0, 1'b0, 32'd2, 16'h0000);
    bStep("b_b2b_c2", 2'b00, 0, 16'h0000);
    bStep("b_b2b_c3", 2'b01, 0, 16'hBEEF);
    bStep("b_b2b_c4", 2'b01, 0, 16'h1357);
    bStep("b_b2b_c5", 2'b00, 0, 16'h0000);

    // Reset with a read in flight: the response must never appear.
    bDrive(1, 1'b0, 32'd2, 16'h0000);
    @(negedge clk);
    bValid = 2'b00;
    bReset = 1'b1;
    #1;
    checkOutput("b_drop_rsp_data", bRspData, 32'd0);
    checkOutput("b_drop_init_done", 32'(bInitDone), 32'd0);
    bStep("b_drop_c2", 2'b00, 1, 16'h0000);
    bStep("b_drop_c3", 2'b00, 1, 16'h0000);
    bStep("b_drop_c4", 2'b00, 1, 16'h0000);
    bReset = 1'b0;
    bStep("b_drop_c5", 2'b00, 1, 16'h0000);
    bStep("b_drop_c6", 2'b00, 1, 16'h0000);
    checkOutput("b_drop_init_again", 32'(bInitDone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
